// File: rtl/pcm_rom_fetch_arbiter.sv
// Two byte-wide PCM requesters share one 64-bit DDRAM read channel; each keeps a one-line cache.
// Define PCM_LINE_CACHE_EN to keep line storage; otherwise every read fetches from DDRAM.

module pcm_rom_lane #(
  parameter int AW = 18
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          i_rd,
  input  logic [AW-1:0] i_addr,
  input  logic          i_fill,
  input  logic [63:0]   i_line,
  output logic          o_pend,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_data,
  output logic          o_rdy
);
  logic          r_pend, r_rdy;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_data;
  logic          w_hit;
  logic [7:0]    w_hit_byte;

`ifdef PCM_LINE_CACHE_EN
  logic [63:0]   r_line;
  logic [AW-4:0] r_tag;
  logic          r_valid;

  // flush forces the miss path even before valid has dropped
  assign w_hit      = r_valid & ~flush & (r_tag == i_addr[AW-1:3]);
  assign w_hit_byte = r_line[{i_addr[2:0], 3'b000} +: 8];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_line  <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (flush) r_valid <= 1'b0;
      if (i_fill) begin
        r_line  <= i_line;
        r_tag   <= r_addr[AW-1:3];
        r_valid <= ~flush;
      end
    end
  end
`else
  logic w_unused_flush;
  assign w_unused_flush = flush;
  assign w_hit          = 1'b0;
  assign w_hit_byte     = 8'h00;
`endif

  // a read arriving while a miss is outstanding is dropped
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= 1'b0;
      r_rdy  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_rdy <= 1'b0;
      if (i_fill) begin
        r_pend <= 1'b0;
        r_rdy  <= 1'b1;
        r_data <= i_line[{r_addr[2:0], 3'b000} +: 8];
      end else if (i_rd && !r_pend) begin
        r_addr <= i_addr;
        if (w_hit) begin
          r_rdy  <= 1'b1;
          r_data <= w_hit_byte;
        end else begin
          r_pend <= 1'b1;
        end
      end
    end
  end

  assign o_pend = r_pend;
  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_rdy  = r_rdy;
endmodule

module pcm_rom_fetch_arbiter #(
  parameter int AW = 18
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                flush,
  input  logic [1:0]          rq_rd,
  input  logic [1:0][AW-1:0]  rq_addr,
  output logic [1:0][7:0]     rq_data,
  output logic [1:0]          rq_rdy,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_req,
  input  logic                mem_ready,
  input  logic [63:0]         mem_dout
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              r_state, w_state_nx;
  logic                r_gnt, r_rr, w_gnt_nx;
  logic [AW-1:0]       r_mem_addr;
  logic [1:0]          w_pend, w_fill;
  logic [1:0][AW-1:0]  w_paddr;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    pcm_rom_lane #(.AW(AW)) u_lane (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .flush   (flush),
      .i_rd    (rq_rd[g]),
      .i_addr  (rq_addr[g]),
      .i_fill  (w_fill[g]),
      .i_line  (mem_dout),
      .o_pend  (w_pend[g]),
      .o_addr  (w_paddr[g]),
      .o_data  (rq_data[g]),
      .o_rdy   (rq_rdy[g])
    );
  end

  assign w_gnt_nx = (w_pend == 2'b11) ? r_rr : w_pend[1];
  assign mem_addr = r_mem_addr;

  always_comb begin
    w_state_nx = r_state;
    w_fill     = '0;
    mem_req    = 1'b0;
    case (r_state)
      S_IDLE:  if (|w_pend) w_state_nx = S_ISSUE;
      S_ISSUE: begin
        mem_req    = 1'b1;
        w_state_nx = S_WAIT;
      end
      S_WAIT: if (mem_ready) begin
        w_state_nx     = S_IDLE;
        w_fill[r_gnt]  = 1'b1;
        // the other requester rides along when it waits on the same line
        w_fill[~r_gnt] = w_pend[~r_gnt] &&
                         (w_paddr[~r_gnt][AW-1:3] == w_paddr[r_gnt][AW-1:3]);
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= 1'b0;
      r_rr       <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE && |w_pend) begin
        r_gnt      <= w_gnt_nx;
        r_mem_addr <= {w_paddr[w_gnt_nx][AW-1:3], 3'b000};
      end
      if (r_state == S_WAIT && mem_ready) r_rr <= ~r_gnt;
    end
  end
endmodule
